// File: rtl/tf_exp_gen.sv
// -----------------------------------------------------------------------------
// tf_exp_gen - twiddle-exponent sequencer for the 256-point radix-4 FFT.
//
// On start, walks every stage and butterfly and presents the four twiddle
// exponents of each butterfly on exp0..exp3 (the address ports of the
// four-port twiddle ROM). tf_vld is exp_vld delayed one cycle so it lines up
// with the ROM's registered read data.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   one-cycle request to sequence a full FFT (IDLE only)
//   stall    in   datapath back-pressure, freezes sequencing in RUN
//   busy     out  high while a sequence is in progress
//   done     out  one-cycle pulse in the FLUSH cycle
//   exp0..3  out  exponents for butterfly legs 0..3 (ROM addresses)
//   exp_vld  out  exp0..exp3 carry a newly issued butterfly this cycle
//   tf_vld   out  exp_vld delayed one cycle, qualifies ROM data
//   stage    out  stage index of the current exponents
//   bfly     out  butterfly index within the stage
//
// Build option: define TFGEN_DIT_EN for decimation-in-time exponent ordering;
// the default build produces decimation-in-frequency ordering.
// -----------------------------------------------------------------------------
module tf_exp_gen #(
  parameter int NSTAGE = 4,
  parameter int EXP_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      stall,
  output logic                      busy,
  output logic                      done,
  output logic [EXP_W-1:0]          exp0,
  output logic [EXP_W-1:0]          exp1,
  output logic [EXP_W-1:0]          exp2,
  output logic [EXP_W-1:0]          exp3,
  output logic                      exp_vld,
  output logic                      tf_vld,
  output logic [$clog2(NSTAGE)-1:0] stage,
  output logic [EXP_W-3:0]          bfly
);

  localparam int STG_W = $clog2(NSTAGE);
  localparam int BF_W  = EXP_W - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [STG_W-1:0]  stage_r, stage_s;
  logic [BF_W-1:0]   bfly_r, bfly_s;
  logic [EXP_W-1:0]  exp1_r, exp2_r, exp3_r;
  logic [EXP_W-1:0]  e1_s;
  logic              exp_vld_r, exp_vld_s;
  logic              tf_vld_r;
  logic              done_r, done_s;
  logic              busy_r;

  // Butterfly-walk helpers derived from the current position.
  logic [BF_W-1:0]   mask_s;     // j = bfly & mask_s
  logic [EXP_W-1:0]  step_s;     // e1 increment per j step
  logic              j_wrap_s;   // j is at its last value in this group
  logic              last_s;     // last butterfly of the last stage
  logic [EXP_W-1:0]  nxt_e1_s;
`ifdef TFGEN_DIT_EN
  logic [STG_W-1:0]  dit_sh_s;
`endif

  // Group mask and exponent step for the current stage.
  always_comb begin
`ifdef TFGEN_DIT_EN
    // DIT: group size 4^s butterflies, step 4^(NSTAGE-1-s).
    dit_sh_s = STG_W'(NSTAGE - 1) - stage_r;
    mask_s   = ~({BF_W{1'b1}} << {stage_r, 1'b0});
    step_s   = EXP_W'(1) << {dit_sh_s, 1'b0};
`else
    // DIF: group size 64/4^s butterflies, step 4^s.
    mask_s   = {BF_W{1'b1}} >> {stage_r, 1'b0};
    step_s   = EXP_W'(1) << {stage_r, 1'b0};
`endif
    j_wrap_s = ((bfly_r & mask_s) == mask_s);
    last_s   = (stage_r == STG_W'(NSTAGE - 1)) && (bfly_r == {BF_W{1'b1}});
    // A stage change always coincides with a j wrap, so e1 restarts at 0.
    if (j_wrap_s) begin
      nxt_e1_s = {EXP_W{1'b0}};
    end else begin
      nxt_e1_s = exp1_r + step_s;
    end
  end

  // Next-state and next-output logic of the sequencer FSM.
  always_comb begin
    state_s   = state_r;
    stage_s   = stage_r;
    bfly_s    = bfly_r;
    e1_s      = exp1_r;
    exp_vld_s = 1'b0;
    done_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s   = RUN;
          stage_s   = {STG_W{1'b0}};
          bfly_s    = {BF_W{1'b0}};
          e1_s      = {EXP_W{1'b0}};
          exp_vld_s = 1'b1;
        end else begin
          state_s   = IDLE;
        end
      end
      RUN: begin
        // The butterfly on the outputs is consumed only if it was presented
        // with exp_vld; a stall-held butterfly stays put until reissued.
        if (exp_vld_r) begin
          if (last_s) begin
            state_s = FLUSH;
            done_s  = 1'b1;
          end else begin
            stage_s   = bfly_r == {BF_W{1'b1}} ? stage_r + STG_W'(1) : stage_r;
            bfly_s    = bfly_r + BF_W'(1);
            e1_s      = nxt_e1_s;
            exp_vld_s = ~stall;
          end
        end else begin
          exp_vld_s = ~stall;
        end
      end
      FLUSH: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      stage_r   <= {STG_W{1'b0}};
      bfly_r    <= {BF_W{1'b0}};
      exp1_r    <= {EXP_W{1'b0}};
      exp2_r    <= {EXP_W{1'b0}};
      exp3_r    <= {EXP_W{1'b0}};
      exp_vld_r <= 1'b0;
      tf_vld_r  <= 1'b0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      stage_r   <= stage_s;
      bfly_r    <= bfly_s;
      exp1_r    <= e1_s;
      exp2_r    <= e1_s << 1;
      exp3_r    <= e1_s + (e1_s << 1);
      exp_vld_r <= exp_vld_s;
      tf_vld_r  <= exp_vld_r;
      done_r    <= done_s;
      busy_r    <= (state_s != IDLE);
    end
  end

  assign exp0    = {EXP_W{1'b0}};  // leg 0 twiddle is always W^0
  assign exp1    = exp1_r;
  assign exp2    = exp2_r;
  assign exp3    = exp3_r;
  assign exp_vld = exp_vld_r;
  assign tf_vld  = tf_vld_r;
  assign done    = done_r;
  assign busy    = busy_r;
  assign stage   = stage_r;
  assign bfly    = bfly_r;

endmodule

// File: tb/tb_tf_exp_gen.sv
// -----------------------------------------------------------------------------
// tb_tf_exp_gen - self-checking bench for tf_exp_gen.
// Model: butterfly n of a run is stage n/64, bfly n%64, with exponents from
// the closed-form twiddle rule. A behavioural ROM checks tf_vld alignment.
// -----------------------------------------------------------------------------
module tb_tf_exp_gen;

  logic       clk = 1'b0;
  logic       rst_n, start, stall;
  logic       busy, done, exp_vld, tf_vld;
  logic [7:0] exp0, exp1, exp2, exp3;
  logic [1:0] stage;
  logic [5:0] bfly;

  int   total = 0;
  int   bad   = 0;
  int   n     = 0;      // index of the next butterfly expected in this run
  logic prev_vld = 1'b0;
  logic [15:0] q0, q1, q2, q3;

  tf_exp_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .busy(busy), .done(done),
    .exp0(exp0), .exp1(exp1), .exp2(exp2), .exp3(exp3),
    .exp_vld(exp_vld), .tf_vld(tf_vld), .stage(stage), .bfly(bfly)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_f(input logic [7:0] e);
    return {e, ~e} ^ 16'h5A3C;
  endfunction

  // Twiddle ROM with one-cycle read latency.
  always @(posedge clk) begin
    q0 <= rom_f(exp0);
    q1 <= rom_f(exp1);
    q2 <= rom_f(exp2);
    q3 <= rom_f(exp3);
  end

  function automatic int model_exp(input int s, input int b, input int m);
    int step, grp, j;
`ifdef TFGEN_DIT_EN
    step = 4 ** (3 - s);
    grp  = 4 ** s;
`else
    step = 4 ** s;
    grp  = 64 / (4 ** s);
`endif
    j = b % grp;
    return (m * j * step) % 256;
  endfunction

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Advance one cycle and compare the DUT against the model.
  task automatic tick();
    logic [7:0]  ev [4];
    logic [15:0] qv [4];
    @(negedge clk);
    ev[0] = exp0; ev[1] = exp1; ev[2] = exp2; ev[3] = exp3;
    qv[0] = q0;   qv[1] = q1;   qv[2] = q2;   qv[3] = q3;
    if (!rst_n) begin
      n        = 0;
      prev_vld = 1'b0;
    end else begin
      chk("tf_vld_align", tf_vld, prev_vld);
      if (tf_vld && n > 0) begin
        for (int m = 0; m < 4; m++)
          chk($sformatf("rom_q%0d", m), qv[m],
              rom_f(8'(model_exp((n - 1) / 64, (n - 1) % 64, m))));
      end
      if (exp_vld) begin
        if (n < 256) begin
          chk("stage", stage, n / 64);
          chk("bfly", bfly, n % 64);
          for (int m = 0; m < 4; m++)
            chk($sformatf("exp%0d", m), ev[m], model_exp(n / 64, n % 64, m));
        end else begin
          chk("extra_bfly", n, 255);
        end
        n++;
      end
      if (done) begin
        chk("done_count", n, 256);
        n = 0;
      end
      prev_vld = exp_vld;
    end
  endtask

  // Hand-computed exponent literals: index = stage*64 + bfly.
`ifdef TFGEN_DIT_EN
  localparam int LIT_N = 3;
  int lit_idx [LIT_N] = '{5, 63, 213};
  int lit_e1  [LIT_N] = '{0, 0, 21};
  int lit_e2  [LIT_N] = '{0, 0, 42};
  int lit_e3  [LIT_N] = '{0, 0, 63};
`else
  localparam int LIT_N = 5;
  int lit_idx [LIT_N] = '{5, 63, 81, 192, 255};
  int lit_e1  [LIT_N] = '{5, 63, 4, 0, 0};
  int lit_e2  [LIT_N] = '{10, 126, 8, 0, 0};
  int lit_e3  [LIT_N] = '{15, 189, 12, 0, 0};
`endif

  task automatic run(input int stall_idx, input int nst, input bit mid);
    int t, nv, left, hits, idx;
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 1; nv = 0; left = 0; hits = 0;
    chk("busy_first", busy, 1);
    chk("vld_first", exp_vld, 1);
    while (t < 400 && !done) begin
      idx = stage * 64 + bfly;
      chk("busy_run", busy, 1);
      if (exp_vld) begin
        nv++;
        chk("exp0_zero", exp0, 0);
        for (int k = 0; k < LIT_N; k++) begin
          if (idx == lit_idx[k]) begin
            hits++;
            chk("lit_e1", exp1, lit_e1[k]);
            chk("lit_e2", exp2, lit_e2[k]);
            chk("lit_e3", exp3, lit_e3[k]);
          end
        end
      end else begin
        chk("held_idx", idx, stall_idx);
        if (stall_idx >= 0)
          chk("held_exp1", exp1, model_exp(stall_idx / 64, stall_idx % 64, 1));
      end
      if (exp_vld && stall_idx > 0 && idx == stall_idx - 1) left = nst;
      stall = (left > 0);
      if (left > 0) left--;
      start = (mid && t == 50);
      tick();
      t++;
    end
    stall = 1'b0;
    start = 1'b0;
    chk("done_cycle", t, 257 + nst);
    chk("vld_cycles", nv, 256);
    chk("lit_hits", hits, LIT_N);
    chk("busy_at_done", busy, 1);
    chk("tf_vld_flush", tf_vld, 1);
    chk("vld_in_flush", exp_vld, 0);
    tick();
    chk("done_pulse_len", done, 0);
    chk("busy_idle", busy, 0);
  endtask

  task automatic reset_values(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_exps"}, {exp0, exp1, exp2, exp3}, 0);
    chk({nm, "_vld"}, exp_vld, 0);
    chk({nm, "_tf"}, tf_vld, 0);
    chk({nm, "_stage"}, stage, 0);
    chk({nm, "_bfly"}, bfly, 0);
  endtask

  initial begin
    int guard;
    rst_n = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    #1;
    reset_values("rst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    run(-1, 0, 1'b0);   // clean run
    run(138, 3, 1'b0);  // stall 3 cycles at stage 2 bfly 10
    run(-1, 0, 1'b1);   // stray start mid-run

    // Abort with reset at stage 1 bfly 30.
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (!(exp_vld && stage == 2'd1 && bfly == 6'd30) && guard < 300) begin
      tick();
      guard++;
    end
    chk("abort_reached", guard < 300, 1);
    rst_n = 1'b0;
    #1;
    reset_values("abort");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", done, 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_idle", busy, 0);
      chk("abort_no_done2", done, 0);
    end
    run(-1, 0, 1'b0);   // restart from stage 0 bfly 0

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
